cfg_loader: RTL and testbench
=============================

Name: cfg_loader

Overview:
Host-side front end for the cipher's 67-bit serial configuration chain. It accepts the new configuration as 9 bytes over a valid/ready byte interface. It then drives cfg_en/cfg_i for exactly 67 contiguous cycles to shift the frame in. In the same cycles it captures the displaced contents from cfg_o and returns them as 9 readback bytes. It sits directly upstream of the cipher's cfg_en/cfg_i/cfg_o pins.

Parameters:
CFG_BITS, 67, length of the downstream configuration chain; NBYTES = ceil(CFG_BITS/8) = 9 (localparam).
RB_ENABLE, 1, 1 = emit readback bytes after each shift; 0 = skip the READBACK state.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_data  in  8  configuration byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
flush  in  1  synchronous; discard a partially collected frame
cfg_en  out  1  shift enable to the chain, registered
cfg_i  out  1  serial config bit to the chain, registered
cfg_o  in  1  serial bit returned from the chain
rb_data  out  8  readback byte
rb_valid  out  1  rb_data valid
rb_ready  in  1  consumer accepts a readback byte
busy  out  1  high in SHIFT or READBACK
done  out  1  one-cycle pulse when the shift completes

Behaviour:
- Reset values: cfg_en=0, cfg_i=0, rb_valid=0, rb_data=0, busy=0, done=0, byte counter=0, state=COLLECT, frame and readback registers all 0.
- Frame format: byte j carries frame bits [8j+7:8j]. Byte 8 carries bits [66:64] in [2:0]; bits [7:3] of byte 8 are ignored.
- Frame fields: bit 66 = k_mux, bit 65 = a_mux, bit 64 = d_en, [63:32] = taps, [31:0] = LFSR state.
- State COLLECT:
  - in_ready=1.
  - Each in_valid&in_ready writes the byte at the current index and increments the index.
  - Accepting byte 8 moves the FSM to SHIFT on the next edge.
  - flush=1 clears the index to 0 and the byte is not accepted that cycle (in_ready=0 while flush=1). Flush has priority over in_valid.
- State SHIFT:
  - in_ready=0. A 7-bit bit counter k runs 0..66.
  - During cycle k: cfg_en=1 and cfg_i=frame[k] (LSB first), so frame[0] ends in chain bit 0 after 67 shifts.
  - At the same edge the chain shifts, cfg_o is sampled into rb[k] (old chain bit k).
  - cfg_en is high for exactly 67 consecutive cycles, never split and never high outside SHIFT. The downstream 67-count load pulse depends on this.
  - flush is ignored in SHIFT.
  - After k=66: cfg_en=0 and cfg_i=0 on the next cycle. done pulses for one cycle in that same cycle.
  - The FSM then goes to READBACK, or to COLLECT when RB_ENABLE=0.
- State READBACK:
  - Emits rb bytes 0..8 in the same packing as the frame; bits [7:3] of byte 8 are 0.
  - rb_valid stays high, and rb_data holds stable, until rb_ready. Each handshake advances one byte.
  - After byte 8 is accepted the FSM returns to COLLECT with the index at 0.
  - in_ready=0 throughout READBACK.
- busy=1 exactly in SHIFT and READBACK.
- Reset mid-operation: all outputs return to reset values immediately. A partial chain shift is not completed.
- Latency: byte 8 accepted at edge N gives first cfg_en=1 in the cycle after edge N, last cfg_en in cycle N+67, and done=1 in cycle N+68.

Decomposition:
- Shared package holds: CFG_BITS=67, NBYTES, the state enum (COLLECT, SHIFT, READBACK), and field bit positions (K_MUX_BIT=66, A_MUX_BIT=65, D_EN_BIT=64, TAPS_LSB=32, STATE_LSB=0).
- Natural sub-module: cfg_byte_packer. It is a 9-byte addressable register file with byte write/read against a 72-bit vector, instantiated twice (frame and readback).
- The FSM and bit counter stay in cfg_loader.

Test Plan:
All scenarios use a behavioural 67-bit shift-register stub as the chain model. It shifts {cfg_i, reg[66:1]} when cfg_en=1, with cfg_o=reg[0].
1. Preload the stub with 0x0_00000060_00000055, then send bytes 55 00 00 00 60 00 00 00 04 -> cfg_en high exactly 67 cycles. Stub ends at {1,0,0,0x00000060,0x00000055}. done pulses once. Readback bytes = 55 00 00 00 60 00 00 00 00.
2. Back-to-back frames A, B -> readback of B equals A. in_ready=0 from A's byte 8 until A's readback completes.
3. Send 4 bytes, assert flush, then send a full 9-byte frame -> stub contains only the 9-byte frame. No cfg_en pulses before byte 9 of that frame.
4. Hold rb_ready=0 for 10 cycles mid-readback -> rb_valid stays 1 and rb_data stays stable. No byte is lost or duplicated.
5. Assert rst at shift cycle k=30 -> cfg_en=0 and busy=0 immediately, state=COLLECT. A subsequent full frame loads correctly.
6. Run with RB_ENABLE=0 -> rb_valid never asserts. in_ready returns to 1 the cycle after done.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// Shared constants and types for the cipher configuration loader.
// Chain length, byte packing and frame field positions.
package cfg_loader_pkg;

    localparam int CFG_BITS = 67;
    localparam int NBYTES   = (CFG_BITS + 7) / 8;
    localparam int VEC_BITS = NBYTES * 8;

    localparam int K_MUX_BIT = 66;
    localparam int A_MUX_BIT = 65;
    localparam int D_EN_BIT  = 64;
    localparam int TAPS_LSB  = 32;
    localparam int STATE_LSB = 0;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        SHIFT    = 2'd1,
        READBACK = 2'd2
    } state_t;

endpackage

// File: rtl/cfg_loader_if.sv
// Host byte stream in, readback byte stream out.
// master = host side, slave = loader side.
interface cfg_loader_if;
    import cfg_loader_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic       rb_ready;

    modport master (
        output in_data, in_valid, flush, rb_ready,
        input  in_ready, rb_data, rb_valid
    );

    modport slave (
        input  in_data, in_valid, flush, rb_ready,
        output in_ready, rb_data, rb_valid
    );

endinterface

// File: rtl/cfg_byte_packer.sv
// 9-byte register file viewed as one flat vector.
// Byte-wide write port plus a single-bit write port.
module cfg_byte_packer
    import cfg_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_byte_we,
    input  logic [3:0]          i_byte_addr,
    input  logic [7:0]          i_byte_data,
    input  logic                i_bit_we,
    input  logic [6:0]          i_bit_addr,
    input  logic                i_bit_data,
    output logic [VEC_BITS-1:0] o_vec
);

    logic [VEC_BITS-1:0] r_vec;

    // Byte writes win; the owner never uses both ports at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_vec <= '0;
        else if (i_byte_we)
            r_vec[{i_byte_addr, 3'b000} +: 8] <= i_byte_data;
        else if (i_bit_we)
            r_vec[i_bit_addr] <= i_bit_data;
    end

    assign o_vec = r_vec;

endmodule

// File: rtl/cfg_loader.sv
// Collects a 9-byte frame, shifts it into the 67-bit chain,
// and returns the displaced chain contents as readback bytes.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter bit RB_ENABLE = 1'b1
)
(
    input  logic   clk,
    input  logic   rst,
    cfg_loader_if.slave bus,
    output logic   cfg_en,
    output logic   cfg_i,
    input  logic   cfg_o,
    output logic   busy,
    output logic   done
);

    localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);
    localparam logic [6:0] LAST_BIT  = 7'(K_MUX_BIT);
    localparam logic [6:0] TAIL      = 7'(CFG_BITS);

    state_t r_state;
    state_t w_next;

    logic [3:0] r_idx;
    logic [6:0] r_k;
    logic       r_cfg_en;
    logic       r_cfg_i;
    logic       r_done;

    logic       w_in_ready;
    logic       w_rb_valid;
    logic [7:0] w_rb_data;
    logic       w_busy;
    logic       w_accept;
    logic       w_rb_fire;
    logic       w_last_byte;
    logic [6:0] w_k_next;

    logic [VEC_BITS-1:0] w_frame;
    logic [VEC_BITS-1:0] w_rb;

    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_rb_fire   = w_rb_valid & bus.rb_ready;
    assign w_last_byte = (r_idx == LAST_BYTE);
    assign w_k_next    = r_k + 7'd1;

    cfg_byte_packer u_frame (
        .clk         (clk),
        .rst         (rst),
        .i_byte_we   (w_accept),
        .i_byte_addr (r_idx),
        .i_byte_data (bus.in_data),
        .i_bit_we    (1'b0),
        .i_bit_addr  (7'd0),
        .i_bit_data  (1'b0),
        .o_vec       (w_frame)
    );

    cfg_byte_packer u_rb (
        .clk         (clk),
        .rst         (rst),
        .i_byte_we   (1'b0),
        .i_byte_addr (4'd0),
        .i_byte_data (8'd0),
        .i_bit_we    (r_cfg_en),
        .i_bit_addr  (r_k),
        .i_bit_data  (cfg_o),
        .o_vec       (w_rb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= COLLECT;
        else
            r_state <= w_next;
    end

    // Next state; SHIFT holds one extra cycle for the done pulse.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            COLLECT:
                if (w_accept && w_last_byte)
                    w_next = SHIFT;
            SHIFT:
                if (r_k == TAIL)
                    w_next = RB_ENABLE ? READBACK : COLLECT;
            READBACK:
                if (w_rb_fire && w_last_byte)
                    w_next = COLLECT;
            default:
                w_next = COLLECT;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        w_in_ready = 1'b0;
        w_rb_valid = 1'b0;
        w_rb_data  = '0;
        w_busy     = 1'b0;
        unique case (r_state)
            COLLECT:
                w_in_ready = ~bus.flush;
            SHIFT:
                w_busy = 1'b1;
            READBACK: begin
                w_busy     = 1'b1;
                w_rb_valid = 1'b1;
                w_rb_data  = w_rb[{r_idx, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // Byte index, bit counter and registered chain drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_k      <= '0;
            r_cfg_en <= 1'b0;
            r_cfg_i  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                COLLECT: begin
                    if (bus.flush) begin
                        r_idx <= '0;
                    end else if (w_accept) begin
                        if (w_last_byte) begin
                            r_idx    <= '0;
                            r_k      <= '0;
                            r_cfg_en <= 1'b1;
                            r_cfg_i  <= w_frame[0];
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_k == LAST_BIT) begin
                        r_cfg_en <= 1'b0;
                        r_cfg_i  <= 1'b0;
                        r_done   <= 1'b1;
                        r_k      <= TAIL;
                    end else if (r_cfg_en) begin
                        r_k     <= w_k_next;
                        r_cfg_i <= w_frame[w_k_next];
                    end
                end
                READBACK: begin
                    if (w_rb_fire)
                        r_idx <= w_last_byte ? 4'd0 : r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.rb_valid = w_rb_valid;
    assign bus.rb_data  = w_rb_data;
    assign busy         = w_busy;
    assign cfg_en       = r_cfg_en;
    assign cfg_i        = r_cfg_i;
    assign done         = r_done;

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader against a 67-bit shift-register chain stub.
// Expected chain/readback come from byte packing of frames.
module tb_cfg_loader;
    import cfg_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfg_loader_if bus ();
    cfg_loader_if bus2 ();

    logic en1, ci1, co1, busy1, done1;
    logic en2, ci2, co2, busy2, done2;

    cfg_loader #(.RB_ENABLE(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cfg_en (en1),
        .cfg_i  (ci1),
        .cfg_o  (co1),
        .busy   (busy1),
        .done   (done1)
    );

    cfg_loader #(.RB_ENABLE(1'b0)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus2),
        .cfg_en (en2),
        .cfg_i  (ci2),
        .cfg_o  (co2),
        .busy   (busy2),
        .done   (done2)
    );

    logic [66:0] ch1, ch2, pre_val;
    logic        pre = 1'b0;

    always @(posedge clk) begin
        if (pre) ch1 <= pre_val;
        else if (en1) ch1 <= {ci1, ch1[66:1]};
    end
    always @(posedge clk) begin
        if (pre) ch2 <= pre_val;
        else if (en2) ch2 <= {ci2, ch2[66:1]};
    end
    assign co1 = ch1[0];
    assign co2 = ch2[0];

    int n_cmp = 0;
    int n_bad = 0;
    int mon_bad = 0;
    logic [66:0] model;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((en1 && !busy1) || (busy1 && bus.in_ready) ||
                (en2 && !busy2) || (busy2 && bus2.in_ready) ||
                bus2.rb_valid) begin
                mon_bad++;
                if (mon_bad < 5)
                    $display("FAIL monitor t=%0t en1=%b busy1=%b rdy1=%b en2=%b busy2=%b rdy2=%b rbv2=%b",
                             $time, en1, busy1, bus.in_ready,
                             en2, busy2, bus2.in_ready, bus2.rb_valid);
            end
        end
    end

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    task automatic preload(input logic [66:0] v);
        @(negedge clk);
        pre_val = v;
        pre = 1'b1;
        @(negedge clk);
        pre = 1'b0;
        model = v;
    endtask

    task automatic send_bytes(input logic [71:0] fv, input int n,
                              output int pre_en);
        pre_en = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            bus.in_data  = fv[8*j +: 8];
            bus.in_valid = 1'b1;
            for (int t = 0; t < 40 && !bus.in_ready; t++)
                @(negedge clk);
            chk("in_ready", 72'(bus.in_ready), 72'd1);
            pre_en += int'(en1);
            @(posedge clk);
        end
    endtask

    task automatic run_frame(input logic [71:0] fv, input logic [66:0] ec,
                             input logic [71:0] erb, input int stall,
                             input int rst_at);
        int pre_en, en_cnt, s;
        logic done_pre;
        logic [7:0] d0;
        logic [133:0] cat;
        send_bytes(fv, 9, pre_en);
        chk("pre_en", 72'(pre_en), 72'd0);
        en_cnt = 0;
        done_pre = 1'b0;
        for (int j = 1; j <= 67; j++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (j == rst_at + 1) begin
                rst = 1'b1;
                #1;
                chk("rst_mid", 72'({en1, ci1, busy1, done1,
                    bus.rb_valid, bus.in_ready}), 72'b000001);
                cat = {fv[66:0], model} >> rst_at;
                model = cat[66:0];
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            en_cnt += int'(en1);
            done_pre |= done1;
        end
        @(negedge clk);
        chk("cfg_en_cycles", 72'(en_cnt), 72'd67);
        chk("done_early", 72'(done_pre), 72'd0);
        chk("done_pulse", 72'({en1, ci1, done1, busy1}), 72'b0011);
        chk("chain", 72'(ch1), 72'(ec));
        model = fv[66:0];
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            bus.rb_ready = 1'b0;
            if (j == 0) chk("done_once", 72'(done1), 72'd0);
            for (int t = 0; t < 20 && !bus.rb_valid; t++)
                @(negedge clk);
            s = (stall == 1) ? int'($urandom_range(0, 3)) :
                (stall == 2 && j == 4) ? 10 : 0;
            d0 = bus.rb_data;
            for (int i = 0; i < s; i++) begin
                @(negedge clk);
                chk("rb_hold", 72'({bus.rb_valid, bus.rb_data}),
                    72'({1'b1, d0}));
            end
            chk("rb_byte", 72'({bus.rb_valid, bus.rb_data}),
                72'({1'b1, erb[8*j +: 8]}));
            bus.rb_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.rb_ready = 1'b0;
        chk("rb_end", 72'({bus.rb_valid, busy1, bus.in_ready}), 72'b001);
    endtask

    typedef struct packed {
        logic        load;
        logic [66:0] pre;
        logic [71:0] fv;
        logic [66:0] chain;
        logic [71:0] rb;
    } vec_t;

    vec_t tv[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [71:0] fv;
        int pe, en_cnt;
        tv[0] = '{1'b1, 67'h0_00000060_00000055,
                  72'h04_00000060_00000055,
                  67'h4_00000060_00000055,
                  72'h00_00000060_00000055};
        tv[1] = '{1'b1, 67'h7_FFFFFFFF_FFFFFFFF,
                  72'hFF_EFCDAB89_67452301,
                  67'h7_EFCDAB89_67452301,
                  72'h07_FFFFFFFF_FFFFFFFF};
        tv[2] = '{1'b1, 67'h5_12345678_9ABCDEF0,
                  72'hFA_00000000_00000000,
                  67'h2_00000000_00000000,
                  72'h05_12345678_9ABCDEF0};
        tv[3] = '{1'b0, 67'h0,
                  72'h01_A5A5A5A5_5A5A5A5A,
                  67'h1_A5A5A5A5_5A5A5A5A,
                  72'h02_00000000_00000000};

        bus.in_data = '0;  bus.in_valid = 1'b0;
        bus.flush = 1'b0;  bus.rb_ready = 1'b0;
        bus2.in_data = '0; bus2.in_valid = 1'b0;
        bus2.flush = 1'b0; bus2.rb_ready = 1'b0;
        pre_val = '0;
        model = '0;

        repeat (3) @(negedge clk);
        chk("reset_outs", 72'({en1, ci1, busy1, done1, bus.rb_valid,
            bus.rb_data, en2, busy2, done2, bus2.rb_valid}), 72'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 72'({bus.in_ready, busy1, bus2.in_ready, busy2}),
            72'b1010);

        for (int i = 0; i < 4; i++) begin
            if (tv[i].load) preload(tv[i].pre);
            run_frame(tv[i].fv, tv[i].chain, tv[i].rb, 0, -1);
        end

        for (int r = 0; r < 6; r++) begin
            fv = rnd72();
            run_frame(fv, fv[66:0], {5'b0, model}, 1, -1);
        end

        fv = rnd72();
        run_frame(fv, fv[66:0], {5'b0, model}, 2, -1);

        send_bytes(72'hEE_DDCCBBAA_99887766, 4, pe);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        #1;
        chk("flush_ready", 72'(bus.in_ready), 72'd0);
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        fv = rnd72();
        run_frame(fv, fv[66:0], {5'b0, model}, 0, -1);

        fv = rnd72();
        run_frame(fv, 67'h0, 72'h0, 0, 30);
        fv = rnd72();
        run_frame(fv, fv[66:0], {5'b0, model}, 1, -1);

        fv = rnd72();
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            bus2.in_data = fv[8*j +: 8];
            bus2.in_valid = 1'b1;
            for (int t = 0; t < 40 && !bus2.in_ready; t++)
                @(negedge clk);
            chk("nrb_in_ready", 72'(bus2.in_ready), 72'd1);
            @(posedge clk);
        end
        en_cnt = 0;
        for (int j = 1; j <= 69; j++) begin
            @(negedge clk);
            bus2.in_valid = 1'b0;
            if (j <= 67) en_cnt += int'(en2);
            if (j == 68)
                chk("nrb_done", 72'({en2, done2, busy2, bus2.in_ready}),
                    72'b0110);
            if (j == 69)
                chk("nrb_ready", 72'({done2, busy2, bus2.in_ready}),
                    72'b001);
        end
        chk("nrb_en_cycles", 72'(en_cnt), 72'd67);
        chk("nrb_chain", 72'(ch2), 72'(fv[66:0]));

        chk("monitor", 72'(mon_bad), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
